// File: rtl/gamma_cycle_sequencer.sv
// One gamma cycle: clear the decoder bank, run a MAX_VALUE+1 tick window that
// latches each line's first spike as MAX_VALUE - tick, then stream the results out.
module gamma_cycle_sequencer #(
  parameter int MAX_VALUE = 8,
  parameter int NUM_LINES = 4,
  localparam int W = $clog2(MAX_VALUE + 1),
  localparam int IW = (NUM_LINES > 1) ? $clog2(NUM_LINES) : 1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic [NUM_LINES-1:0] incoming_lines,
  output logic                 busy,
  output logic                 decoder_clear,
  output logic                 window_active,
  output logic [W-1:0]         tick,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [IW-1:0]        out_index,
  output logic [W-1:0]         out_value,
  output logic                 out_fired,
  output logic                 done,
  output logic [1:0]           state
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] CLEAR  = 2'd1;
  localparam logic [1:0] WINDOW = 2'd2;
  localparam logic [1:0] DRAIN  = 2'd3;

  // Handshake: a result transfers in any cycle with out_valid & out_ready; while
  // out_valid is high and out_ready low, index/value/fired hold and valid stays up.

  logic [W-1:0]         value [NUM_LINES];
  logic [NUM_LINES-1:0] fired;

  logic [1:0]           state_n;
  logic [W-1:0]         tick_n;
  logic [W-1:0]         value_n [NUM_LINES];
  logic [NUM_LINES-1:0] fired_n;
  logic [IW-1:0]        index_n;
  logic                 valid_n;
  logic                 done_n;
  logic [W-1:0]         out_value_n;
  logic                 out_fired_n;

  always_comb begin
    state_n = state;
    tick_n  = tick;
    value_n = value;
    fired_n = fired;
    index_n = out_index;
    valid_n = out_valid;
    done_n  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_n = CLEAR;
          tick_n  = '0;
        end
      end
      CLEAR: begin
        for (int i = 0; i < NUM_LINES; i++) value_n[i] = '0;
        fired_n = '0;
        tick_n  = '0;
        state_n = WINDOW;
      end
      WINDOW: begin
        for (int i = 0; i < NUM_LINES; i++) begin
          if (!fired[i] && incoming_lines[i]) begin
            value_n[i] = W'(MAX_VALUE) - tick;
            fired_n[i] = 1'b1;
          end
        end
        if (tick == W'(MAX_VALUE)) begin
          state_n = DRAIN;
          tick_n  = '0;
          index_n = '0;
          valid_n = 1'b1;
        end else begin
          tick_n = tick + W'(1);
        end
      end
      default: begin
        if (out_valid && out_ready) begin
          if (out_index == IW'(NUM_LINES - 1)) begin
            state_n = IDLE;
            valid_n = 1'b0;
            index_n = '0;
            done_n  = 1'b1;
          end else begin
            index_n = out_index + IW'(1);
          end
        end
      end
    endcase
    // Uses the post-capture values so a spike at the last tick reaches line 0's output.
    out_value_n = valid_n ? value_n[index_n] : '0;
    out_fired_n = valid_n ? fired_n[index_n] : 1'b0;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      tick          <= '0;
      for (int i = 0; i < NUM_LINES; i++) value[i] <= '0;
      fired         <= '0;
      out_index     <= '0;
      out_valid     <= 1'b0;
      out_value     <= '0;
      out_fired     <= 1'b0;
      done          <= 1'b0;
      busy          <= 1'b0;
      decoder_clear <= 1'b0;
      window_active <= 1'b0;
    end else begin
      state         <= state_n;
      tick          <= tick_n;
      value         <= value_n;
      fired         <= fired_n;
      out_index     <= index_n;
      out_valid     <= valid_n;
      out_value     <= out_value_n;
      out_fired     <= out_fired_n;
      done          <= done_n;
      busy          <= (state_n != IDLE);
      decoder_clear <= (state_n == CLEAR);
      window_active <= (state_n == WINDOW);
    end
  end

endmodule

// File: tb/tb_gamma_cycle_sequencer.sv
// Bench for gamma_cycle_sequencer: hand-written vector table, reset/chaining
// corner cases, and random windows scored against a first-spike reference model.
module tb_gamma_cycle_sequencer;
  localparam int MAX_VALUE = 8;
  localparam int NUM_LINES = 4;
  localparam int W = $clog2(MAX_VALUE + 1);
  localparam int IW = (NUM_LINES > 1) ? $clog2(NUM_LINES) : 1;

  logic                 clock = 1'b0;
  logic                 reset;
  logic                 start;
  logic [NUM_LINES-1:0] incoming_lines;
  logic                 busy, decoder_clear, window_active;
  logic [W-1:0]         tick;
  logic                 out_valid, out_ready;
  logic [IW-1:0]        out_index;
  logic [W-1:0]         out_value;
  logic                 out_fired;
  logic                 done;
  logic [1:0]           state;

  gamma_cycle_sequencer #(.MAX_VALUE(MAX_VALUE), .NUM_LINES(NUM_LINES)) dut (
    .clock(clock), .reset(reset), .start(start), .incoming_lines(incoming_lines),
    .busy(busy), .decoder_clear(decoder_clear), .window_active(window_active),
    .tick(tick), .out_valid(out_valid), .out_ready(out_ready),
    .out_index(out_index), .out_value(out_value), .out_fired(out_fired),
    .done(done), .state(state)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int passed = 0;
  int cyc = 0;
  logic [W:0] exp_q[$];
  logic [NUM_LINES-1:0] sched [0:MAX_VALUE];

  typedef struct {
    int                   first [NUM_LINES];
    int                   second [NUM_LINES];
    logic [NUM_LINES-1:0] pre;
    int                   stall_idx;
    int                   stall_len;
    bit                   chain;
    int                   exp_value [NUM_LINES];
    int                   exp_fired [NUM_LINES];
  } vec_t;

  vec_t vecs [5];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic step();
    @(posedge clock);
    #1;
    cyc++;
  endtask

  // Reference: a line's value is MAX_VALUE minus the first tick its spike appears.
  task automatic model_push();
    for (int i = 0; i < NUM_LINES; i++) begin
      int first_t = -1;
      for (int t = 0; t <= MAX_VALUE; t++)
        if (first_t < 0 && sched[t][i]) first_t = t;
      if (first_t < 0) exp_q.push_back({1'b0, W'(0)});
      else exp_q.push_back({1'b1, W'(MAX_VALUE - first_t)});
    end
  endtask

  task automatic run_window(input bit started, input logic [NUM_LINES-1:0] pre,
                            input int stall_idx, input int stall_len, input bit chain);
    int c0;
    logic [W:0] exp;
    logic [IW+W:0] held;
    if (!started) begin
      start = 1'b1;
      incoming_lines = pre;
      step();
    end
    c0 = cyc - 1;
    start = 1'b0;
    incoming_lines = pre;
    check("clear_strobe", int'(decoder_clear), 1);
    check("clear_busy", int'(busy), 1);
    check("clear_window", int'(window_active), 0);
    step();
    for (int t = 0; t <= MAX_VALUE; t++) begin
      check("win_active", int'(window_active), 1);
      check("win_tick", int'(tick), t);
      check("win_no_clear", int'(decoder_clear), 0);
      incoming_lines = sched[t];
      start = (t == 3);
      step();
    end
    start = 1'b0;
    incoming_lines = '1;
    check("drain_start_cycle", cyc - c0, 3 + MAX_VALUE);
    for (int i = 0; i < NUM_LINES; i++) begin
      check("drain_valid", int'(out_valid), 1);
      check("drain_index", int'(out_index), i);
      check("drain_no_done", int'(done), 0);
      if (exp_q.size() == 0) begin
        check("scoreboard_empty", 1, 0);
        exp = '0;
      end else exp = exp_q.pop_front();
      check("result", int'({out_fired, out_value}), int'(exp));
      if (i == stall_idx && stall_len > 0) begin
        held = {out_index, out_fired, out_value};
        out_ready = 1'b0;
        for (int k = 0; k < stall_len; k++) begin
          step();
          check("stall_valid", int'(out_valid), 1);
          check("stall_hold", int'({out_index, out_fired, out_value}), int'(held));
        end
        out_ready = 1'b1;
      end
      step();
    end
    check("done_pulse", int'(done), 1);
    check("done_busy", int'(busy), 0);
    check("done_valid", int'(out_valid), 0);
    check("done_cycle", cyc - c0, 3 + MAX_VALUE + NUM_LINES + ((stall_idx >= 0) ? stall_len : 0));
    if (chain) begin
      start = 1'b1;
      step();
    end else begin
      step();
      check("done_single", int'(done), 0);
    end
  endtask

  task automatic load_vec(input vec_t v);
    for (int t = 0; t <= MAX_VALUE; t++) sched[t] = '0;
    for (int i = 0; i < NUM_LINES; i++) begin
      if (v.first[i] >= 0) sched[v.first[i]][i] = 1'b1;
      if (v.second[i] >= 0) sched[v.second[i]][i] = 1'b1;
      exp_q.push_back({v.exp_fired[i] != 0, W'(v.exp_value[i])});
    end
  endtask

  initial begin
    bit started;
    reset = 1'b1;
    start = 1'b0;
    incoming_lines = '0;
    out_ready = 1'b1;
    repeat (2) step();
    check("rst_busy", int'(busy), 0);
    check("rst_valid", int'(out_valid), 0);
    check("rst_done", int'(done), 0);
    check("rst_tick", int'(tick), 0);
    check("rst_outs", int'({out_index, out_value, out_fired, decoder_clear, window_active}), 0);
    reset = 1'b0;
    step();

    vecs[0] = '{first:'{0, 3, 8, -1}, second:'{-1, -1, -1, -1}, pre:'0, stall_idx:-1,
                stall_len:0, chain:0, exp_value:'{8, 5, 0, 0}, exp_fired:'{1, 1, 1, 0}};
    vecs[1] = '{first:'{-1, 2, -1, -1}, second:'{-1, 5, -1, -1}, pre:'1, stall_idx:-1,
                stall_len:0, chain:0, exp_value:'{0, 6, 0, 0}, exp_fired:'{0, 1, 0, 0}};
    vecs[2] = '{first:'{1, 4, 7, 0}, second:'{-1, 6, 8, 2}, pre:'0, stall_idx:1,
                stall_len:3, chain:0, exp_value:'{7, 4, 1, 8}, exp_fired:'{1, 1, 1, 1}};
    vecs[3] = '{first:'{8, 8, 8, 8}, second:'{-1, -1, -1, -1}, pre:'0, stall_idx:-1,
                stall_len:0, chain:1, exp_value:'{0, 0, 0, 0}, exp_fired:'{1, 1, 1, 1}};
    vecs[4] = '{first:'{-1, -1, -1, -1}, second:'{-1, -1, -1, -1}, pre:'1, stall_idx:3,
                stall_len:1, chain:0, exp_value:'{0, 0, 0, 0}, exp_fired:'{0, 0, 0, 0}};
    started = 1'b0;
    for (int v = 0; v < 5; v++) begin
      load_vec(vecs[v]);
      run_window(started, vecs[v].pre, vecs[v].stall_idx, vecs[v].stall_len, vecs[v].chain);
      started = vecs[v].chain;
    end

    // Reset mid-window after line 0 has already captured.
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    for (int t = 0; t < 4; t++) begin
      incoming_lines = (t == 0) ? 4'b0001 : 4'b0000;
      step();
    end
    check("pre_reset_tick", int'(tick), 4);
    #2 reset = 1'b1;
    #1;
    check("async_busy", int'(busy), 0);
    check("async_tick", int'(tick), 0);
    check("async_window", int'(window_active), 0);
    check("async_outs", int'({out_valid, out_index, out_value, out_fired, done, decoder_clear}), 0);
    @(negedge clock);
    reset = 1'b0;
    incoming_lines = '0;
    step();
    check("post_reset_idle_valid", int'(out_valid), 0);
    for (int t = 0; t <= MAX_VALUE; t++) sched[t] = '0;
    sched[1] = 4'b0010;
    exp_q.push_back({1'b0, W'(0)});
    exp_q.push_back({1'b1, W'(7)});
    exp_q.push_back({1'b0, W'(0)});
    exp_q.push_back({1'b0, W'(0)});
    run_window(1'b0, '0, -1, 0, 1'b0);

    // Random windows against the reference model.
    started = 1'b0;
    for (int r = 0; r < 25; r++) begin
      bit chain;
      int sidx, slen;
      for (int t = 0; t <= MAX_VALUE; t++) sched[t] = '0;
      for (int i = 0; i < NUM_LINES; i++) begin
        int f;
        f = $urandom_range(0, MAX_VALUE + 1);
        if (f <= MAX_VALUE) begin
          sched[f][i] = 1'b1;
          for (int t = f + 1; t <= MAX_VALUE; t++)
            if ($urandom_range(0, 3) == 0) sched[t][i] = 1'b1;
        end
      end
      model_push();
      sidx = $urandom_range(0, NUM_LINES - 1);
      slen = $urandom_range(0, 3);
      chain = ($urandom_range(0, 1) == 1);
      run_window(started, NUM_LINES'($urandom), sidx, slen, chain);
      started = chain;
    end
    if (started) begin
      // Finish the window the last chained start opened.
      for (int t = 0; t <= MAX_VALUE; t++) sched[t] = '0;
      model_push();
      run_window(1'b1, '0, -1, 0, 1'b0);
    end
    check("scoreboard_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $display("%0d/%0d checks passed", passed, checks + 1);
    $finish;
  end

endmodule

// File: doc/gamma_cycle_sequencer.md
# gamma_cycle_sequencer

Sequences one temporal-coding computation window ("gamma cycle") for a bank of spike lines. It clears the downstream pulse-decoder bank and runs a tick counter from 0 to MAX_VALUE. During the window it latches each line's first-spike value as MAX_VALUE − tick, which matches the pulse-decoder value convention. It then streams the per-line results out over a valid/ready port. It sits between the spike source and the readout/learning logic, and owns all window timing for the counter datapath.

## Interface
- MAX_VALUE, 8, largest encoded value; the window lasts MAX_VALUE+1 ticks
- NUM_LINES, 4, number of spike lines sequenced (≥1)
- W (local), $clog2(MAX_VALUE+1), value and tick width
- IW (local), max(1, $clog2(NUM_LINES)), index width

Ports:
- clock  in  1  clock
- reset  in  1  reset, asynchronous, active-high
- start  in  1  request a new cycle; honoured only in IDLE
- incoming_lines  in  NUM_LINES  spike lines, one bit per line
- busy  out  1  high in CLEAR, WINDOW and DRAIN
- decoder_clear  out  1  clear strobe to the decoder bank, high in CLEAR only
- window_active  out  1  high in WINDOW only
- tick  out  W  elapsed ticks in the current window
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts the result
- out_index  out  IW  line number of the presented result
- out_value  out  W  decoded value; 0 if the line never fired
- out_fired  out  1  line spiked during the window
- done  out  1  single-cycle end-of-cycle pulse

## Operation
- FSM states: IDLE, CLEAR, WINDOW, DRAIN.
- IDLE → CLEAR when start=1. Otherwise the FSM stays in IDLE. start is ignored in every other state.
- CLEAR (exactly 1 cycle):
  - decoder_clear=1.
  - All capture registers clear: value=0, fired=0.
  - tick=0.
  - Next state is WINDOW.
- WINDOW (MAX_VALUE+1 cycles, tick = 0..MAX_VALUE):
  - For each line i with fired[i]=0 and incoming_lines[i]=1: value[i] ← MAX_VALUE − tick and fired[i] ← 1.
  - Only the first spike counts. Later spikes on an already-fired line are ignored.
  - Any number of lines can capture in the same cycle.
  - A spike at tick=MAX_VALUE captures value 0 with fired=1.
  - Once tick=MAX_VALUE, the next state is DRAIN and tick returns to 0. tick never wraps inside a window.
- DRAIN:
  - Presents line 0 through NUM_LINES−1 in order, each on out_index/out_value/out_fired with out_valid=1.
  - A handshake is out_valid & out_ready, and it advances the index.
  - After the handshake on line NUM_LINES−1, the next state is IDLE and done=1.
- Spikes seen in IDLE, CLEAR or DRAIN are ignored.
- Asynchronous reset forces IDLE and clears all state at any point, including mid-window or mid-drain.
- After reset, no partial results are emitted.

## Timing
- All outputs are registered. Reset values are 0 for busy, decoder_clear, window_active, tick, out_valid, out_index, out_value, out_fired and done.
- Cycle numbering from a start sampled high in IDLE during cycle C:
  - CLEAR occupies C+1.
  - WINDOW occupies C+2 .. C+2+MAX_VALUE, with tick=t in cycle C+2+t.
  - A spike sampled in cycle C+2+t yields the value MAX_VALUE−t.
  - DRAIN begins at C+3+MAX_VALUE, with out_valid=1 and out_index=0.
- With out_ready held at 1, line i is presented in cycle C+3+MAX_VALUE+i.
- done=1 and busy=0 occur in cycle C+3+MAX_VALUE+NUM_LINES.
- For MAX_VALUE=8 and NUM_LINES=4: DRAIN starts at C+11 and done occurs at C+15.
- Backpressure: while out_valid=1 and out_ready=0, out_index/out_value/out_fired hold stable. out_valid never drops without a handshake.
- done lasts exactly 1 cycle, while the FSM is in IDLE. A start in the done cycle is accepted, giving back-to-back cycles with no idle gap.

## Test plan
- Spikes on line0 at tick 0, line1 at tick 3, line2 at tick 8, no spike on line3, out_ready=1 → results (0,8,1), (1,5,1), (2,0,1), (3,0,0); done in cycle C+15.
- Line1 spikes at tick 2 and again at tick 5 → out_value=6 for index 1. Spikes in IDLE and CLEAR → no effect (value 0, fired 0).
- out_ready held low for 3 cycles while index 1 is presented → index 1 and its data stable across all 3 cycles; out_valid stays 1; no index skipped; done delayed by 3 cycles.
- start pulsed during WINDOW → ignored. start asserted in the done cycle → CLEAR in the next cycle.
- decoder_clear high for exactly one cycle (C+1). window_active high for exactly 9 cycles with tick stepping 0..8.
- reset asserted at tick 4 with line0 already captured → all outputs 0 immediately. The next start produces fresh results, line0 shows fired=0 if it does not spike again.
